// File: rtl/pipe_pkg.sv
// Shared types for the memory-stage controller: size codes, FSM states and
// the per-stage op records, plus the alignment rule.
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {ST_RUN, ST_MERGE} state_t;

  typedef struct packed {
    logic        valid;
    logic        rmem;
    logic        wmem;
    logic        wreg;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
  } mop_t;

  typedef struct packed {
    logic        valid;
    logic        rmem;
    logic        wreg;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  rd;
    logic [1:0]  off;
    logic [31:0] alu;
    logic        err;
  } trk_t;

  // Reserved size 2'b11 is treated as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/pipe_mem_ctrl_if.sv
// EX-side request, data-memory port and MEM/WB result bundle of the memory stage.
// slave is the controller's view; master is the surrounding pipeline and memory.
interface pipe_mem_ctrl_if;
  logic        ex_valid;
  logic        ex_rmem;
  logic        ex_wmem;
  logic        ex_wreg;
  logic [1:0]  ex_size;
  logic        ex_sign;
  logic [4:0]  ex_rd;
  logic [31:0] ex_addr;
  logic [31:0] ex_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  modport slave (
    input  ex_valid, ex_rmem, ex_wmem, ex_wreg, ex_size, ex_sign, ex_rd, ex_addr, ex_data,
    input  mem_dout,
    output in_ready, mem_addr, mem_din, mem_we,
    output wb_valid, wb_wreg, wb_rd, wb_data, wb_err
  );

  modport master (
    output ex_valid, ex_rmem, ex_wmem, ex_wreg, ex_size, ex_sign, ex_rd, ex_addr, ex_data,
    output mem_dout,
    input  in_ready, mem_addr, mem_din, mem_we,
    input  wb_valid, wb_wreg, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/byte_lane.sv
// Combinational byte-lane steering: merges sub-word store data into a memory word
// and extracts/extends sub-word load data, in little (0) or big (1) lane order.
module byte_lane
  import pipe_pkg::*;
#(
  parameter int ENDIAN = 0
) (
  input  logic [31:0] old_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  output logic [31:0] new_word,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_sign,
  output logic [31:0] ld_result
);

  // Bit position of the addressed byte/half; halves use only off[1].
  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
    logic [4:0] sh;
    case (size)
      SZ_BYTE: sh = (ENDIAN != 0) ? {~off, 3'b000} : {off, 3'b000};
      SZ_HALF: sh = {((ENDIAN != 0) ? ~off[1] : off[1]), 4'b0000};
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] data,
                                        input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = lane_shift(off, size);
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF;
      SZ_HALF: mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_w & ~(mask << sh)) | ((data & mask) << sh);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic sign);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> lane_shift(off, size);
    case (size)
      SZ_BYTE: r = {{24{sign & s[7]}}, s[7:0]};
      SZ_HALF: r = {{16{sign & s[15]}}, s[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign new_word  = merge(old_word, st_data, st_off, st_size);
  assign ld_result = extract(ld_word, ld_off, ld_size, ld_sign);

endmodule

// File: rtl/pipe_mem_ctrl.sv
// Memory-stage controller: M stage drives the memory, T tracks the op, WB is registered
// (latency 2); sub-word stores read-modify-write and drop in_ready for one cycle.
module pipe_mem_ctrl
  import pipe_pkg::*;
#(
  parameter int ENDIAN      = 0,
  parameter int CHECK_ALIGN = 1
) (
  input  logic          clk,
  input  logic          rst,
  pipe_mem_ctrl_if.slave bus
);

  state_t      state;
  mop_t        m;
  trk_t        t;
  logic        m_mis;
  logic        m_sub_store;
  logic        rmw_start;
  logic        accept;
  logic [31:0] merged;
  logic [31:0] loaded;

  assign m_mis       = (CHECK_ALIGN != 0) && (m.rmem || m.wmem) && misaligned(m.size, m.addr[1:0]);
  assign m_sub_store = m.valid && m.wmem && !m_mis && (m.size == SZ_BYTE || m.size == SZ_HALF);
  assign rmw_start   = (state == ST_RUN) && m_sub_store;

  assign bus.in_ready = !rst && !rmw_start;
  assign accept       = bus.ex_valid && bus.in_ready;

  assign bus.mem_addr = {m.addr[31:2], 2'b00};
  assign bus.mem_din  = (state == ST_MERGE) ? merged : m.data;
  // The read half of a read-modify-write issues no write; reset abandons a pending merge.
  assign bus.mem_we   = !rst && m.valid && m.wmem && !m_mis && ((state == ST_MERGE) || !m_sub_store);

  byte_lane #(.ENDIAN(ENDIAN)) u_lane (
    .old_word (bus.mem_dout),
    .st_data  (m.data),
    .st_off   (m.addr[1:0]),
    .st_size  (m.size),
    .new_word (merged),
    .ld_word  (bus.mem_dout),
    .ld_off   (t.off),
    .ld_size  (t.size),
    .ld_sign  (t.sign),
    .ld_result(loaded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      m            <= '0;
      t            <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_wreg  <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.wb_err   <= 1'b0;
    end else begin
      case (state)
        ST_RUN:   if (rmw_start) state <= ST_MERGE;
        ST_MERGE: state <= ST_RUN;
      endcase

      if (accept) begin
        m <= '{valid: 1'b1, rmem: bus.ex_rmem, wmem: bus.ex_wmem, wreg: bus.ex_wreg,
               size: bus.ex_size, sign: bus.ex_sign, rd: bus.ex_rd,
               addr: bus.ex_addr, data: bus.ex_data};
      end else if (!rmw_start) begin
        m.valid <= 1'b0;
      end

      // The RMW op is tracked only once, on its MERGE cycle.
      t <= '{valid: m.valid && !rmw_start, rmem: m.rmem, wreg: m.wreg && !m.wmem,
             size: m.size, sign: m.sign, rd: m.rd, off: m.addr[1:0],
             alu: m.addr, err: m_mis};

      bus.wb_valid <= t.valid;
      bus.wb_wreg  <= t.valid && t.wreg && !t.err;
      bus.wb_rd    <= t.valid ? t.rd : 5'd0;
      bus.wb_err   <= t.valid && t.err;
      bus.wb_data  <= (!t.valid || t.err) ? 32'd0 : (t.rmem ? loaded : t.alu);
    end
  end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench: little- and big-endian controllers share one op stream, each
// with its own synchronous word memory model; expected values are hand-computed.
module tb_pipe_mem_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_mem_ctrl_if le_if();
  pipe_mem_ctrl_if be_if();

  pipe_mem_ctrl #(.ENDIAN(0), .CHECK_ALIGN(1)) u_le (.clk(clk), .rst(rst), .bus(le_if));
  pipe_mem_ctrl #(.ENDIAN(1), .CHECK_ALIGN(1)) u_be (.clk(clk), .rst(rst), .bus(be_if));

  assign be_if.ex_valid = le_if.ex_valid;
  assign be_if.ex_rmem  = le_if.ex_rmem;
  assign be_if.ex_wmem  = le_if.ex_wmem;
  assign be_if.ex_wreg  = le_if.ex_wreg;
  assign be_if.ex_size  = le_if.ex_size;
  assign be_if.ex_sign  = le_if.ex_sign;
  assign be_if.ex_rd    = le_if.ex_rd;
  assign be_if.ex_addr  = le_if.ex_addr;
  assign be_if.ex_data  = le_if.ex_data;

  logic [31:0] mem_le [0:63];
  logic [31:0] mem_be [0:63];

  always @(posedge clk) begin
    if (le_if.mem_we) mem_le[le_if.mem_addr[7:2]] <= le_if.mem_din;
    le_if.mem_dout <= mem_le[le_if.mem_addr[7:2]];
    if (be_if.mem_we) mem_be[be_if.mem_addr[7:2]] <= be_if.mem_din;
    be_if.mem_dout <= mem_be[be_if.mem_addr[7:2]];
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic        wreg;
    logic [31:0] data;
  } wbrec_t;
  wbrec_t wb_q[$];

  always @(negedge clk)
    if (le_if.wb_valid) wb_q.push_back('{rd: le_if.wb_rd, wreg: le_if.wb_wreg, data: le_if.wb_data});

  typedef struct packed {
    logic        r, w, wr;
    logic [1:0]  sz;
    logic        sg;
    logic [4:0]  rd;
    logic [31:0] a, d;
  } op_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic r, input logic w, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [4:0] rd, input logic [31:0] a,
                             input logic [31:0] d);
    return '{r: r, w: w, wr: wr, sz: sz, sg: sg, rd: rd, a: a, d: d};
  endfunction

  task automatic op(input op_t o);
    le_if.ex_valid = 1'b1;
    le_if.ex_rmem  = o.r;
    le_if.ex_wmem  = o.w;
    le_if.ex_wreg  = o.wr;
    le_if.ex_size  = o.sz;
    le_if.ex_sign  = o.sg;
    le_if.ex_rd    = o.rd;
    le_if.ex_addr  = o.a;
    le_if.ex_data  = o.d;
  endtask

  task automatic idle();
    op(mk(0, 0, 0, 2'b00, 0, 5'd0, 32'd0, 32'd0));
    le_if.ex_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ready"},    le_if.in_ready, 1);
    check_eq({tag, "_we"},       le_if.mem_we, 0);
    check_eq({tag, "_addr"},     le_if.mem_addr, 0);
    check_eq({tag, "_din"},      le_if.mem_din, 0);
    check_eq({tag, "_wb_valid"}, le_if.wb_valid, 0);
    check_eq({tag, "_wb_wreg"},  le_if.wb_wreg, 0);
    check_eq({tag, "_wb_rd"},    le_if.wb_rd, 0);
    check_eq({tag, "_wb_data"},  le_if.wb_data, 0);
    check_eq({tag, "_wb_err"},   le_if.wb_err, 0);
  endtask

  op_t         stream [8];
  logic [31:0] s_exp  [8];
  int          base;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    mid();
    check_eq("rst_in_ready_low", le_if.in_ready, 0);
    tick();
    rst = 1'b0;
    mid();
    check_quiet("reset");

    // Word store then word load to the same address.
    tick();
    op(mk(0, 1, 0, SZ_WORD, 0, 5'd0, 32'h10, 32'hDEADBEEF));
    mid(); check_eq("t1_sw_ready", le_if.in_ready, 1);
    tick();
    op(mk(1, 0, 1, SZ_WORD, 0, 5'd5, 32'h10, 32'd0));
    mid();
    check_eq("t1_sw_we", le_if.mem_we, 1);
    check_eq("t1_sw_addr", le_if.mem_addr, 32'h10);
    check_eq("t1_sw_din", le_if.mem_din, 32'hDEADBEEF);
    check_eq("t1_lw_ready", le_if.in_ready, 1);
    tick();
    idle();
    mid();
    check_eq("t1_lw_we", le_if.mem_we, 0);
    check_eq("t1_lw_addr", le_if.mem_addr, 32'h10);
    tick();
    mid();
    check_eq("t1_sw_wb_valid", le_if.wb_valid, 1);
    check_eq("t1_sw_wb_wreg", le_if.wb_wreg, 0);
    tick();
    mid();
    check_eq("t1_lw_wb_valid", le_if.wb_valid, 1);
    check_eq("t1_lw_wb_wreg", le_if.wb_wreg, 1);
    check_eq("t1_lw_wb_rd", le_if.wb_rd, 5);
    check_eq("t1_lw_wb_data", le_if.wb_data, 32'hDEADBEEF);

    // Byte store read-modify-write, then signed and unsigned byte loads.
    tick();
    op(mk(0, 1, 0, SZ_WORD, 0, 5'd0, 32'h20, 32'h11223344));
    mid(); tick();
    op(mk(0, 1, 0, SZ_BYTE, 0, 5'd0, 32'h21, 32'h555555AA));
    mid(); check_eq("t2_sb_ready", le_if.in_ready, 1);
    tick();
    op(mk(1, 0, 1, SZ_BYTE, 1, 5'd7, 32'h21, 32'd0));
    mid();
    check_eq("t2_read_stall", le_if.in_ready, 0);
    check_eq("t2_read_we", le_if.mem_we, 0);
    check_eq("t2_read_addr", le_if.mem_addr, 32'h20);
    tick();
    mid();
    check_eq("t2_merge_ready", le_if.in_ready, 1);
    check_eq("t2_merge_we", le_if.mem_we, 1);
    check_eq("t2_merge_din_le", le_if.mem_din, 32'h1122AA44);
    check_eq("t2_merge_din_be", be_if.mem_din, 32'h11AA3344);
    tick();
    op(mk(1, 0, 1, SZ_BYTE, 0, 5'd8, 32'h21, 32'd0));
    mid();
    check_eq("t2_mem_le", mem_le[8], 32'h1122AA44);
    check_eq("t2_mem_be", mem_be[8], 32'h11AA3344);
    check_eq("t2_bubble", le_if.wb_valid, 0);
    tick();
    idle();
    mid();
    check_eq("t2_sb_wb_valid", le_if.wb_valid, 1);
    check_eq("t2_sb_wb_wreg", le_if.wb_wreg, 0);
    tick();
    mid();
    check_eq("t2_lb_rd", le_if.wb_rd, 7);
    check_eq("t2_lb_le", le_if.wb_data, 32'hFFFFFFAA);
    check_eq("t2_lb_be", be_if.wb_data, 32'hFFFFFFAA);
    tick();
    mid();
    check_eq("t2_lbu_rd", le_if.wb_rd, 8);
    check_eq("t2_lbu_le", le_if.wb_data, 32'h000000AA);
    check_eq("t2_lbu_be", be_if.wb_data, 32'h000000AA);

    // Halfword store at offset 2, then signed halfword load.
    tick();
    op(mk(0, 1, 0, SZ_WORD, 0, 5'd0, 32'h20, 32'h11223344));
    mid(); tick();
    op(mk(0, 1, 0, SZ_HALF, 0, 5'd0, 32'h22, 32'hABCD8001));
    mid(); tick();
    op(mk(1, 0, 1, SZ_HALF, 1, 5'd9, 32'h22, 32'd0));
    mid(); check_eq("t3_read_stall", le_if.in_ready, 0);
    tick();
    mid(); tick();
    idle();
    mid();
    check_eq("t3_mem_be", mem_be[8], 32'h11228001);
    check_eq("t3_mem_le", mem_le[8], 32'h80013344);
    tick();
    mid(); tick();
    mid();
    check_eq("t3_lh_rd", be_if.wb_rd, 9);
    check_eq("t3_lh_be", be_if.wb_data, 32'hFFFF8001);
    check_eq("t3_lh_le", le_if.wb_data, 32'hFFFF8001);

    // Misaligned load and store are flagged without stalling or touching memory.
    tick();
    op(mk(1, 0, 1, SZ_HALF, 1, 5'd10, 32'h23, 32'd0));
    mid(); check_eq("t4_lh_ready", le_if.in_ready, 1);
    tick();
    op(mk(0, 0, 1, SZ_WORD, 0, 5'd11, 32'h1234, 32'd0));
    mid();
    check_eq("t4_lh_we", le_if.mem_we, 0);
    check_eq("t4_alu_ready", le_if.in_ready, 1);
    tick();
    op(mk(0, 1, 0, SZ_WORD, 0, 5'd12, 32'h21, 32'hFFFFFFFF));
    mid(); check_eq("t4_sw_ready", le_if.in_ready, 1);
    tick();
    idle();
    mid();
    check_eq("t4_lh_wb_valid", le_if.wb_valid, 1);
    check_eq("t4_lh_wb_err", le_if.wb_err, 1);
    check_eq("t4_lh_wb_wreg", le_if.wb_wreg, 0);
    check_eq("t4_sw_we", le_if.mem_we, 0);
    check_eq("t4_sw_no_stall", le_if.in_ready, 1);
    tick();
    mid();
    check_eq("t4_alu_err", le_if.wb_err, 0);
    check_eq("t4_alu_wreg", le_if.wb_wreg, 1);
    check_eq("t4_alu_rd", le_if.wb_rd, 11);
    check_eq("t4_alu_data", le_if.wb_data, 32'h1234);
    tick();
    mid();
    check_eq("t4_sw_wb_err", le_if.wb_err, 1);
    check_eq("t4_sw_wb_wreg", le_if.wb_wreg, 0);
    check_eq("t4_mem_unchanged", mem_le[8], 32'h80013344);

    // Mixed stream of single-cycle ops.
    stream[0] = mk(0, 0, 1, SZ_WORD, 0, 5'd1, 32'h100, 32'd0);        s_exp[0] = 32'h100;
    stream[1] = mk(1, 0, 1, SZ_WORD, 0, 5'd2, 32'h10, 32'd0);         s_exp[1] = 32'hDEADBEEF;
    stream[2] = mk(0, 1, 0, SZ_WORD, 0, 5'd3, 32'h30, 32'hCAFEF00D);  s_exp[2] = 32'd0;
    stream[3] = mk(0, 0, 1, SZ_WORD, 0, 5'd4, 32'h444, 32'd0);        s_exp[3] = 32'h444;
    stream[4] = mk(1, 0, 1, SZ_WORD, 0, 5'd5, 32'h20, 32'd0);         s_exp[4] = 32'h80013344;
    stream[5] = mk(0, 1, 0, SZ_WORD, 0, 5'd6, 32'h34, 32'h12345678);  s_exp[5] = 32'd0;
    stream[6] = mk(0, 0, 1, SZ_WORD, 0, 5'd7, 32'h777, 32'd0);        s_exp[6] = 32'h777;
    stream[7] = mk(1, 0, 1, SZ_WORD, 0, 5'd8, 32'h30, 32'd0);         s_exp[7] = 32'hCAFEF00D;
    tick();
    base = wb_q.size();
    for (int i = 0; i < 8; i++) begin
      op(stream[i]);
      mid();
      check_eq($sformatf("t5_ready_%0d", i), le_if.in_ready, 1);
      tick();
    end
    idle();
    for (int c = 0; c < 20 && wb_q.size() < base + 8; c++) tick();
    check_eq("t5_count", wb_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < wb_q.size()) begin
        check_eq($sformatf("t5_rd_%0d", i), wb_q[base + i].rd, stream[i].rd);
        check_eq($sformatf("t5_wreg_%0d", i), wb_q[base + i].wreg, stream[i].wr);
        if (stream[i].wr) check_eq($sformatf("t5_data_%0d", i), wb_q[base + i].data, s_exp[i]);
      end
    end

    // Reset during MERGE abandons the write.
    tick();
    op(mk(0, 1, 0, SZ_WORD, 0, 5'd0, 32'h40, 32'h01020304));
    mid(); tick();
    op(mk(0, 1, 0, SZ_BYTE, 0, 5'd0, 32'h41, 32'h000000EE));
    mid(); tick();
    idle();
    mid(); check_eq("t6_read_stall", le_if.in_ready, 0);
    tick();
    rst = 1'b1;
    mid();
    check_eq("t6_we_abort", le_if.mem_we, 0);
    check_eq("t6_ready_in_rst", le_if.in_ready, 0);
    tick();
    rst = 1'b0;
    mid();
    check_quiet("t6_post_rst");
    check_eq("t6_mem_unchanged", mem_le[16], 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
